fft_but_r4_pipe: RTL and testbench

// - Pipelined radix-4 DIT butterfly with input twiddle multiply, selectable scaling and saturation,

---
 rtl/fft_pkg.sv | 40 ++++
 rtl/fft_cmul.sv | 61 ++++++
 rtl/fft_but_r4_pipe.sv | 201 ++++++++++++++++++++
 tb/tb_fft_but_r4_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and fixed-point helpers for the FFT butterfly datapath.
// Helpers operate on a wide signed accumulator so callers only narrow once at the end.
package fft_pkg;

   typedef enum logic [1:0] {
      MODE_R4_D4,
      MODE_R4_D2,
      MODE_R4_D1,
      MODE_R2_D2
   } mode_t;

   localparam int unsigned FFT_BUT_LAT = 4;

   localparam int unsigned ACC_W = 48;
   typedef logic signed [ACC_W-1:0] acc_t;

   // Round half up, then arithmetic shift right by s.
   function automatic acc_t round_shr(acc_t v, int unsigned s);
      if (s == 0) begin
         return v;
      end
      return (v + (acc_t'(1) <<< (s - 1))) >>> s;
   endfunction

   // Clamp to the range of a w-bit two's complement number.
   function automatic acc_t sat_to(acc_t v, int unsigned w);
      acc_t hi;
      acc_t lo;
      hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
      lo = -(acc_t'(1) <<< (w - 1));
      if (v > hi) begin
         return hi;
      end
      if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/fft_cmul.sv
// Two-stage complex multiply by a Q1.(TW_BIT-1) twiddle: full-width product, then round.
// Bypass substitutes an exact 1.0 so the rounding stage returns X unchanged.
module fft_cmul
   import fft_pkg::*;
#(
   parameter int unsigned BIT    = 17,
   parameter int unsigned TW_BIT = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     en_i,
   input  logic                     byp_i,
   input  logic signed [BIT-1:0]    x_re_i,
   input  logic signed [BIT-1:0]    x_im_i,
   input  logic signed [TW_BIT-1:0] w_re_i,
   input  logic signed [TW_BIT-1:0] w_im_i,
   output logic signed [BIT:0]      y_re_o,
   output logic signed [BIT:0]      y_im_o
);

   localparam int unsigned PW = BIT + TW_BIT + 1;

   logic signed [PW-1:0] prod_re_d, prod_im_d;
   logic signed [PW-1:0] prod_re_q, prod_im_q;
   logic signed [BIT:0]  y_re_d, y_im_d;
   logic signed [BIT:0]  y_re_q, y_im_q;

   always_comb begin
      if (byp_i) begin
         prod_re_d = PW'(x_re_i) <<< (TW_BIT - 1);
         prod_im_d = PW'(x_im_i) <<< (TW_BIT - 1);
      end else begin
         prod_re_d = PW'(x_re_i) * PW'(w_re_i) - PW'(x_im_i) * PW'(w_im_i);
         prod_im_d = PW'(x_re_i) * PW'(w_im_i) + PW'(x_im_i) * PW'(w_re_i);
      end
   end

   // A full-scale negative twiddle can reach exactly 2^BIT; clamp instead of wrapping.
   always_comb begin
      y_re_d = (BIT + 1)'(sat_to(round_shr(acc_t'(prod_re_q), TW_BIT - 1), BIT + 1));
      y_im_d = (BIT + 1)'(sat_to(round_shr(acc_t'(prod_im_q), TW_BIT - 1), BIT + 1));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prod_re_q <= '0;
         prod_im_q <= '0;
         y_re_q    <= '0;
         y_im_q    <= '0;
      end else if (en_i) begin
         prod_re_q <= prod_re_d;
         prod_im_q <= prod_im_d;
         y_re_q    <= y_re_d;
         y_im_q    <= y_im_d;
      end
   end

   assign y_re_o = y_re_q;
   assign y_im_o = y_im_q;

endmodule

// File: rtl/fft_but_r4_pipe.sv
// Four-stage radix-4 DIT butterfly: twiddle multiply, round, butterfly, scale and saturate.
// Mode, inverse flag and valid travel alongside the data so they may change every beat.
module fft_but_r4_pipe
   import fft_pkg::*;
#(
   parameter int unsigned BIT    = 17,
   parameter int unsigned TW_BIT = 16
) (
   input  logic                     iCLK,
   input  logic                     iRESET,
   input  logic                     iEN,
   input  logic                     iVALID,
   input  logic [1:0]               iMODE,
   input  logic                     iINV,
   input  logic                     iTW_BYP,
   input  logic signed [BIT-1:0]    iX0_RE,
   input  logic signed [BIT-1:0]    iX0_IM,
   input  logic signed [BIT-1:0]    iX1_RE,
   input  logic signed [BIT-1:0]    iX1_IM,
   input  logic signed [BIT-1:0]    iX2_RE,
   input  logic signed [BIT-1:0]    iX2_IM,
   input  logic signed [BIT-1:0]    iX3_RE,
   input  logic signed [BIT-1:0]    iX3_IM,
   input  logic signed [TW_BIT-1:0] iW1_RE,
   input  logic signed [TW_BIT-1:0] iW1_IM,
   input  logic signed [TW_BIT-1:0] iW2_RE,
   input  logic signed [TW_BIT-1:0] iW2_IM,
   input  logic signed [TW_BIT-1:0] iW3_RE,
   input  logic signed [TW_BIT-1:0] iW3_IM,
   output logic                     oVALID,
   output logic                     oOVF,
   output logic signed [BIT-1:0]    oY0_RE,
   output logic signed [BIT-1:0]    oY0_IM,
   output logic signed [BIT-1:0]    oY1_RE,
   output logic signed [BIT-1:0]    oY1_IM,
   output logic signed [BIT-1:0]    oY2_RE,
   output logic signed [BIT-1:0]    oY2_IM,
   output logic signed [BIT-1:0]    oY3_RE,
   output logic signed [BIT-1:0]    oY3_IM
);

   logic signed [BIT-1:0]    xk_re [3];
   logic signed [BIT-1:0]    xk_im [3];
   logic signed [TW_BIT-1:0] wk_re [3];
   logic signed [TW_BIT-1:0] wk_im [3];
   logic signed [BIT:0]      tw_re [3];
   logic signed [BIT:0]      tw_im [3];

   logic signed [BIT-1:0]    x0_re_s1_q, x0_im_s1_q, x0_re_s2_q, x0_im_s2_q;
   logic [FFT_BUT_LAT-1:0]   valid_q;
   mode_t                    mode_s1_q, mode_s2_q, mode_s3_q;
   logic                     inv_s1_q, inv_s2_q;

   logic signed [BIT+2:0]    bf_re_d [4];
   logic signed [BIT+2:0]    bf_im_d [4];
   logic signed [BIT+2:0]    bf_re_q [4];
   logic signed [BIT+2:0]    bf_im_q [4];
   logic signed [BIT-1:0]    y_re_d [4];
   logic signed [BIT-1:0]    y_im_d [4];
   logic signed [BIT-1:0]    y_re_q [4];
   logic signed [BIT-1:0]    y_im_q [4];
   logic                     ovf_d, ovf_q;

   assign xk_re = '{iX1_RE, iX2_RE, iX3_RE};
   assign xk_im = '{iX1_IM, iX2_IM, iX3_IM};
   assign wk_re = '{iW1_RE, iW2_RE, iW3_RE};
   assign wk_im = '{iW1_IM, iW2_IM, iW3_IM};

   for (genvar g = 0; g < 3; g++) begin : g_cmul
      fft_cmul #(
         .BIT    (BIT),
         .TW_BIT (TW_BIT)
      ) u_cmul (
         .clk_i  (iCLK),
         .rst_i  (iRESET),
         .en_i   (iEN),
         .byp_i  (iTW_BYP),
         .x_re_i (xk_re[g]),
         .x_im_i (xk_im[g]),
         .w_re_i (wk_re[g]),
         .w_im_i (wk_im[g]),
         .y_re_o (tw_re[g]),
         .y_im_o (tw_im[g])
      );
   end

   // X0 and control are delayed to line up with the two-stage multiplier.
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         x0_re_s1_q <= '0;
         x0_im_s1_q <= '0;
         x0_re_s2_q <= '0;
         x0_im_s2_q <= '0;
         valid_q    <= '0;
         mode_s1_q  <= MODE_R4_D4;
         mode_s2_q  <= MODE_R4_D4;
         inv_s1_q   <= 1'b0;
         inv_s2_q   <= 1'b0;
      end else if (iEN) begin
         x0_re_s1_q <= iX0_RE;
         x0_im_s1_q <= iX0_IM;
         x0_re_s2_q <= x0_re_s1_q;
         x0_im_s2_q <= x0_im_s1_q;
         valid_q    <= {valid_q[FFT_BUT_LAT-2:0], iVALID};
         mode_s1_q  <= mode_t'(iMODE);
         mode_s2_q  <= mode_s1_q;
         inv_s1_q   <= iINV;
         inv_s2_q   <= inv_s1_q;
      end
   end

   always_comb begin
      acc_t ar, ai, br, bi, cr, ci, dr, di;
      acc_t p1r, p1i, p3r, p3i;
      ar  = acc_t'(x0_re_s2_q);
      ai  = acc_t'(x0_im_s2_q);
      br  = acc_t'(tw_re[0]);
      bi  = acc_t'(tw_im[0]);
      cr  = acc_t'(tw_re[1]);
      ci  = acc_t'(tw_im[1]);
      dr  = acc_t'(tw_re[2]);
      di  = acc_t'(tw_im[2]);
      p1r = ar + bi - cr - di;
      p1i = ai - br - ci + dr;
      p3r = ar - bi - cr + di;
      p3i = ai + br - ci - dr;
      if (mode_s2_q == MODE_R2_D2) begin
         bf_re_d[0] = (BIT + 3)'(ar + cr);
         bf_im_d[0] = (BIT + 3)'(ai + ci);
         bf_re_d[1] = (BIT + 3)'(br + dr);
         bf_im_d[1] = (BIT + 3)'(bi + di);
         bf_re_d[2] = (BIT + 3)'(ar - cr);
         bf_im_d[2] = (BIT + 3)'(ai - ci);
         bf_re_d[3] = (BIT + 3)'(br - dr);
         bf_im_d[3] = (BIT + 3)'(bi - di);
      end else begin
         bf_re_d[0] = (BIT + 3)'(ar + br + cr + dr);
         bf_im_d[0] = (BIT + 3)'(ai + bi + ci + di);
         bf_re_d[2] = (BIT + 3)'(ar - br + cr - dr);
         bf_im_d[2] = (BIT + 3)'(ai - bi + ci - di);
         // Inverse rotation is the forward -j/+j outputs exchanged.
         bf_re_d[1] = (BIT + 3)'(inv_s2_q ? p3r : p1r);
         bf_im_d[1] = (BIT + 3)'(inv_s2_q ? p3i : p1i);
         bf_re_d[3] = (BIT + 3)'(inv_s2_q ? p1r : p3r);
         bf_im_d[3] = (BIT + 3)'(inv_s2_q ? p1i : p3i);
      end
   end

   always_comb begin
      int unsigned sh;
      acc_t r, c;
      case (mode_s3_q)
         MODE_R4_D4: sh = 2;
         MODE_R4_D1: sh = 0;
         default:    sh = 1;
      endcase
      ovf_d = 1'b0;
      for (int k = 0; k < 4; k++) begin
         r = round_shr(acc_t'(bf_re_q[k]), sh);
         c = sat_to(r, BIT);
         ovf_d = ovf_d | (c != r);
         y_re_d[k] = BIT'(c);
         r = round_shr(acc_t'(bf_im_q[k]), sh);
         c = sat_to(r, BIT);
         ovf_d = ovf_d | (c != r);
         y_im_d[k] = BIT'(c);
      end
   end

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         for (int k = 0; k < 4; k++) begin
            bf_re_q[k] <= '0;
            bf_im_q[k] <= '0;
            y_re_q[k]  <= '0;
            y_im_q[k]  <= '0;
         end
         mode_s3_q <= MODE_R4_D4;
         ovf_q     <= 1'b0;
      end else if (iEN) begin
         bf_re_q   <= bf_re_d;
         bf_im_q   <= bf_im_d;
         y_re_q    <= y_re_d;
         y_im_q    <= y_im_d;
         mode_s3_q <= mode_s2_q;
         ovf_q     <= ovf_d;
      end
   end

   assign oVALID = valid_q[FFT_BUT_LAT-1];
   assign oOVF   = ovf_q;
   assign oY0_RE = y_re_q[0];
   assign oY0_IM = y_im_q[0];
   assign oY1_RE = y_re_q[1];
   assign oY1_IM = y_im_q[1];
   assign oY2_RE = y_re_q[2];
   assign oY2_IM = y_im_q[2];
   assign oY3_RE = y_re_q[3];
   assign oY3_IM = y_im_q[3];

endmodule

// File: tb/tb_fft_but_r4_pipe.sv
// Directed and randomised-stream bench for the radix-4 butterfly pipe.
module tb_fft_but_r4_pipe;

   typedef struct packed {
      logic             ovf;
      logic [3:0][16:0] yre;
      logic [3:0][16:0] yim;
   } res_t;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               en = 1'b1;
   logic               valid = 1'b0;
   logic [1:0]         mode = 2'd0;
   logic               inv = 1'b0;
   logic               byp = 1'b0;
   logic signed [16:0] xr [4];
   logic signed [16:0] xi [4];
   logic signed [15:0] wr [3];
   logic signed [15:0] wi [3];
   logic               vo, ovf;
   logic signed [16:0] y0r, y0i, y1r, y1i, y2r, y2i, y3r, y3i;
   logic signed [16:0] yr [4];
   logic signed [16:0] yi [4];

   int   n_chk = 0;
   int   n_pass = 0;
   res_t q [$];

   assign yr = '{y0r, y1r, y2r, y3r};
   assign yi = '{y0i, y1i, y2i, y3i};

   always #5 clk = ~clk;

   fft_but_r4_pipe #(
      .BIT    (17),
      .TW_BIT (16)
   ) dut (
      .iCLK    (clk),
      .iRESET  (rst),
      .iEN     (en),
      .iVALID  (valid),
      .iMODE   (mode),
      .iINV    (inv),
      .iTW_BYP (byp),
      .iX0_RE  (xr[0]),
      .iX0_IM  (xi[0]),
      .iX1_RE  (xr[1]),
      .iX1_IM  (xi[1]),
      .iX2_RE  (xr[2]),
      .iX2_IM  (xi[2]),
      .iX3_RE  (xr[3]),
      .iX3_IM  (xi[3]),
      .iW1_RE  (wr[0]),
      .iW1_IM  (wi[0]),
      .iW2_RE  (wr[1]),
      .iW2_IM  (wi[1]),
      .iW3_RE  (wr[2]),
      .iW3_IM  (wi[2]),
      .oVALID  (vo),
      .oOVF    (ovf),
      .oY0_RE  (y0r),
      .oY0_IM  (y0i),
      .oY1_RE  (y1r),
      .oY1_IM  (y1i),
      .oY2_RE  (y2r),
      .oY2_IM  (y2i),
      .oY3_RE  (y3r),
      .oY3_IM  (y3i)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      for (int k = 0; k < 4; k++) begin
         xr[k] = '0;
         xi[k] = '0;
      end
      for (int k = 0; k < 3; k++) begin
         wr[k] = '0;
         wi[k] = '0;
      end
      valid = 1'b0;
      mode  = 2'd0;
      inv   = 1'b0;
      byp   = 1'b0;
   endtask

   // Launch one group and measure cycles until oVALID rises.
   task automatic send_dir(input string tag);
      int lat;
      valid = 1'b1;
      tick();
      valid = 1'b0;
      lat = 1;
      while (!vo && lat < 12) begin
         tick();
         lat++;
      end
      check({tag, ".lat"}, lat, 4);
   endtask

   task automatic exp_y(input string tag, input int e0r, input int e0i, input int e1r,
                        input int e1i, input int e2r, input int e2i, input int e3r,
                        input int e3i, input int eovf);
      check({tag, ".y0r"}, y0r, e0r);
      check({tag, ".y0i"}, y0i, e0i);
      check({tag, ".y1r"}, y1r, e1r);
      check({tag, ".y1i"}, y1i, e1i);
      check({tag, ".y2r"}, y2r, e2r);
      check({tag, ".y2i"}, y2i, e2i);
      check({tag, ".y3r"}, y3r, e3r);
      check({tag, ".y3i"}, y3i, e3i);
      check({tag, ".ovf"}, ovf, eovf);
   endtask

   function automatic longint rs(longint v, int s);
      if (s == 0) return v;
      return (v + (longint'(1) << (s - 1))) >>> s;
   endfunction

   function automatic longint clip(longint v, int w);
      longint hi, lo;
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -(longint'(1) << (w - 1));
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   function automatic res_t model();
      res_t   res;
      longint tr [4];
      longint ti [4];
      longint orr [4];
      longint oi [4];
      longint pr, pi, v, c;
      int     s;
      res = '0;
      tr[0] = xr[0];
      ti[0] = xi[0];
      for (int k = 1; k < 4; k++) begin
         if (byp) begin
            tr[k] = xr[k];
            ti[k] = xi[k];
         end else begin
            pr = longint'(xr[k]) * longint'(wr[k-1]) - longint'(xi[k]) * longint'(wi[k-1]);
            pi = longint'(xr[k]) * longint'(wi[k-1]) + longint'(xi[k]) * longint'(wr[k-1]);
            tr[k] = clip(rs(pr, 15), 18);
            ti[k] = clip(rs(pi, 15), 18);
         end
      end
      if (mode == 2'd3) begin
         orr[0] = tr[0] + tr[2];  oi[0] = ti[0] + ti[2];
         orr[2] = tr[0] - tr[2];  oi[2] = ti[0] - ti[2];
         orr[1] = tr[1] + tr[3];  oi[1] = ti[1] + ti[3];
         orr[3] = tr[1] - tr[3];  oi[3] = ti[1] - ti[3];
      end else begin
         orr[0] = tr[0] + tr[1] + tr[2] + tr[3];
         oi[0]  = ti[0] + ti[1] + ti[2] + ti[3];
         orr[2] = tr[0] - tr[1] + tr[2] - tr[3];
         oi[2]  = ti[0] - ti[1] + ti[2] - ti[3];
         orr[1] = tr[0] + ti[1] - tr[2] - ti[3];
         oi[1]  = ti[0] - tr[1] - ti[2] + tr[3];
         orr[3] = tr[0] - ti[1] - tr[2] + ti[3];
         oi[3]  = ti[0] + tr[1] - ti[2] - tr[3];
         if (inv) begin
            v = orr[1]; orr[1] = orr[3]; orr[3] = v;
            v = oi[1];  oi[1]  = oi[3];  oi[3]  = v;
         end
      end
      s = (mode == 2'd0) ? 2 : ((mode == 2'd2) ? 0 : 1);
      for (int k = 0; k < 4; k++) begin
         v = rs(orr[k], s);
         c = clip(v, 17);
         if (c != v) res.ovf = 1'b1;
         res.yre[k] = 17'(c);
         v = rs(oi[k], s);
         c = clip(v, 17);
         if (c != v) res.ovf = 1'b1;
         res.yim[k] = 17'(c);
      end
      return res;
   endfunction

   // One clock of the stream: record what the edge captures, then score what it emits.
   task automatic step();
      logic               e, vo_prev;
      logic signed [16:0] y0r_prev;
      res_t               x;
      e        = en;
      vo_prev  = vo;
      y0r_prev = y0r;
      if (e && valid) q.push_back(model());
      tick();
      if (!e) begin
         check("str.hold.vld", vo, vo_prev);
         check("str.hold.y0r", y0r, y0r_prev);
      end else if (vo) begin
         if (q.size() == 0) begin
            check("str.extra", 1, 0);
         end else begin
            x = q.pop_front();
            for (int k = 0; k < 4; k++) begin
               check($sformatf("str.y%0dr", k), yr[k], $signed(x.yre[k]));
               check($sformatf("str.y%0di", k), yi[k], $signed(x.yim[k]));
            end
            check("str.ovf", ovf, x.ovf);
         end
      end
   endtask

   initial begin
      int sent;
      int guard;
      bit rst_done;
      clr_in();
      rst = 1'b1;
      tick();
      check("rst.vld", vo, 0);
      check("rst.ovf", ovf, 0);
      check("rst.y0r", y0r, 0);
      check("rst.y3i", y3i, 0);
      rst = 1'b0;
      tick();

      clr_in(); byp = 1'b1; xr[0] = 17'sd4;
      send_dir("imp");
      exp_y("imp", 1, 0, 1, 0, 1, 0, 1, 0, 0);
      tick();
      check("imp.bubble", vo, 0);

      clr_in(); byp = 1'b1; xr[0] = 17'sd2;
      send_dir("rnd_p");
      exp_y("rnd_p", 1, 0, 1, 0, 1, 0, 1, 0, 0);

      clr_in(); byp = 1'b1; xr[0] = -17'sd2;
      send_dir("rnd_n");
      exp_y("rnd_n", 0, 0, 0, 0, 0, 0, 0, 0, 0);

      clr_in(); mode = 2'd1; byp = 1'b1; xr[0] = 17'sd3;
      send_dir("m1");
      exp_y("m1", 2, 0, 2, 0, 2, 0, 2, 0, 0);

      clr_in(); mode = 2'd2; byp = 1'b1;
      for (int k = 0; k < 4; k++) xr[k] = 17'sd30000;
      send_dir("sat");
      exp_y("sat", 65535, 0, 0, 0, 0, 0, 0, 0, 1);

      clr_in(); mode = 2'd2; byp = 1'b1; xi[1] = 17'sd1000;
      send_dir("fwd");
      exp_y("fwd", 0, 1000, 1000, 0, 0, -1000, -1000, 0, 0);

      clr_in(); mode = 2'd2; byp = 1'b1; inv = 1'b1; xi[1] = 17'sd1000;
      send_dir("inv");
      exp_y("inv", 0, 1000, -1000, 0, 0, -1000, 1000, 0, 0);

      clr_in(); mode = 2'd2; xr[1] = 17'sd1000; wi[0] = 16'sd32767;
      send_dir("tw");
      exp_y("tw", 0, 1000, 1000, 0, 0, -1000, -1000, 0, 0);

      clr_in(); mode = 2'd3; byp = 1'b1; inv = 1'b1;
      xr[0] = 17'sd100; xr[1] = 17'sd10; xr[2] = 17'sd40; xr[3] = -17'sd6;
      send_dir("r2");
      exp_y("r2", 70, 0, 2, 0, 30, 0, 8, 0, 0);

      clr_in();
      sent = 0;
      guard = 0;
      rst_done = 1'b0;
      while (sent < 30 && guard < 2000) begin
         guard++;
         en    = ($urandom_range(0, 3) != 0);
         valid = ($urandom_range(0, 4) != 0);
         mode  = 2'($urandom_range(0, 3));
         inv   = 1'($urandom);
         byp   = 1'($urandom);
         for (int k = 0; k < 4; k++) begin
            xr[k] = 17'($urandom);
            xi[k] = 17'($urandom);
         end
         for (int k = 0; k < 3; k++) begin
            wr[k] = 16'($urandom);
            wi[k] = 16'($urandom);
         end
         if (en && valid) sent++;
         step();
         if (sent == 12 && !rst_done) begin
            rst_done = 1'b1;
            rst = 1'b1;
            #1;
            check("mid_rst.vld", vo, 0);
            check("mid_rst.ovf", ovf, 0);
            q.delete();
            tick();
            rst = 1'b0;
            en = 1'b1;
            valid = 1'b0;
            repeat (5) step();
            check("mid_rst.empty", vo, 0);
         end
      end
      check("str.timeout", guard < 2000, 1);

      en = 1'b1;
      valid = 1'b0;
      repeat (8) step();
      check("str.lost", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
